// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: in-order writeback vs. queued mul/div results with forced-stall anti-starvation.
// Optional feature macro WB_ARB_BYPASS_EN: an idle slot with an empty queue writes an MDU result directly.
module wb_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_rd_ena,
  input  logic [4:0]                    pipe_rd_addr,
  input  logic [XLEN-1:0]               pipe_rd_data,
  input  logic                          mdu_valid,
  output logic                          mdu_ready,
  input  logic [4:0]                    mdu_rd_addr,
  input  logic [XLEN-1:0]               mdu_rd_data,
  output logic                          stall_req,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [4:0]      mem_addr [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [SW-1:0]   starve_cnt_reg;

  logic q_nonempty;
  logic pipe_real;
  logic store;
  logic push;
  logic pop;
  logic take_pipe;
  logic take_byp;

  assign q_nonempty = (q_count != '0);
  assign mdu_ready  = (q_count < CW'(FIFO_DEPTH));
  assign stall_req  = (starve_cnt_reg == STARVE_TOP) && q_nonempty;
  assign pipe_real  = pipe_rd_ena && (pipe_rd_addr != 5'd0);
  // x0-destined MDU results are handshaken away but never stored
  assign store      = mdu_valid && mdu_ready && (mdu_rd_addr != 5'd0);
  assign push       = store && !take_byp;

  always_comb begin
    pop       = 1'b0;
    take_pipe = 1'b0;
    take_byp  = 1'b0;
    if (stall_req) begin
      pop = 1'b1;
    end else if (pipe_real) begin
      take_pipe = 1'b1;
    end else if (q_nonempty) begin
      pop = 1'b1;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (store) begin
      take_byp = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= mdu_rd_addr;
      mem_data[wr_ptr_reg] <= mdu_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we          <= 1'b0;
      rf_waddr       <= 5'd0;
      rf_wdata       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      q_count        <= '0;
      starve_cnt_reg <= '0;
    end else begin
      rf_we <= pop || take_pipe || take_byp;
      if (pop) begin
        rf_waddr <= mem_addr[rd_ptr_reg];
        rf_wdata <= mem_data[rd_ptr_reg];
      end else if (take_pipe) begin
        rf_waddr <= pipe_rd_addr;
        rf_wdata <= pipe_rd_data;
      end else if (take_byp) begin
        rf_waddr <= mdu_rd_addr;
        rf_wdata <= mdu_rd_data;
      end

      // Power-of-two depth: pointers wrap by natural overflow
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);

      if (push && !pop)      q_count <= q_count + CW'(1);
      else if (pop && !push) q_count <= q_count - CW'(1);

      if (pop || !q_nonempty)
        starve_cnt_reg <= '0;
      else if (take_pipe && (starve_cnt_reg != STARVE_TOP))
        starve_cnt_reg <= starve_cnt_reg + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus a scoreboard of expected regfile writes.
module tb_wb_port_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pipe_rd_ena = 1'b0;
  logic [4:0]      pipe_rd_addr = '0;
  logic [XLEN-1:0] pipe_rd_data = '0;
  logic            mdu_valid = 1'b0;
  logic            mdu_ready;
  logic [4:0]      mdu_rd_addr = '0;
  logic [XLEN-1:0] mdu_rd_data = '0;
  logic            stall_req;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [$clog2(DEPTH):0] q_count;

  wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_rd_ena(pipe_rd_ena), .pipe_rd_addr(pipe_rd_addr), .pipe_rd_data(pipe_rd_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd_addr(mdu_rd_addr), .mdu_rd_data(mdu_rd_data),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [XLEN-1:0] d; } ent_t;
  typedef struct { int due; logic [4:0] a; logic [XLEN-1:0] d; } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int   starve_m   = 0;
  bit   last_stall = 0;
  bit   last_ready = 1;
  int   cyc        = 0;
  int   checks     = 0;
  int   fails      = 0;
  logic [4:0]      last_a = '0;
  logic [XLEN-1:0] last_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every regfile write must match the oldest expected write, on its due cycle.
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      last_a = '0;
      last_d = '0;
    end else if (rf_we) begin
      if (sb.size() == 0) begin
        chk("rf_we_unexpected", rf_we, 0);
      end else begin
        x = sb.pop_front();
        chk("rf_write_cycle", cyc, x.due);
        chk("rf_waddr", rf_waddr, x.a);
        chk("rf_wdata", rf_wdata, x.d);
        $display("wr  cyc=%0d addr=%0d data=0x%0h", cyc, rf_waddr, rf_wdata);
      end
      last_a = rf_waddr;
      last_d = rf_wdata;
    end else begin
      chk("rf_waddr_hold", rf_waddr, last_a);
      chk("rf_wdata_hold", rf_wdata, last_d);
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        x = sb.pop_front();
        chk("rf_we_missing", rf_we, 1);
      end
    end
  end

  // Called at posedge+1 with inputs driven; evaluates the grant rules for this cycle.
  task automatic step();
    bit   ready_m, stall_m, store, byp_used, was_nonempty;
    ent_t e;
    #2;
    ready_m = (mq.size() < DEPTH);
    stall_m = (starve_m == SMAX) && (mq.size() != 0);
    chk("mdu_ready", mdu_ready, ready_m);
    chk("stall_req", stall_req, stall_m);
    chk("q_count", q_count, mq.size());
    store        = mdu_valid && ready_m && (mdu_rd_addr != 0);
    byp_used     = 0;
    was_nonempty = (mq.size() != 0);
    if (stall_m) begin
      e = mq.pop_front();
      sb.push_back('{cyc + 1, e.a, e.d});
      starve_m = 0;
    end else if (pipe_rd_ena && pipe_rd_addr != 0) begin
      sb.push_back('{cyc + 1, pipe_rd_addr, pipe_rd_data});
      if (was_nonempty) starve_m = (starve_m + 1 > SMAX) ? SMAX : starve_m + 1;
    end else if (was_nonempty) begin
      e = mq.pop_front();
      sb.push_back('{cyc + 1, e.a, e.d});
      starve_m = 0;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (store) begin
      sb.push_back('{cyc + 1, mdu_rd_addr, mdu_rd_data});
      byp_used = 1;
    end
`endif
    if (store && !byp_used) mq.push_back('{mdu_rd_addr, mdu_rd_data});
    last_stall = stall_m;
    last_ready = ready_m;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; a stalled pipe write and an unaccepted MDU result are held as the protocol requires.
  task automatic drv(input bit pe, input logic [4:0] pa, input logic [XLEN-1:0] pd,
                     input bit mv, input logic [4:0] ma, input logic [XLEN-1:0] md);
    if (!last_stall) begin
      pipe_rd_ena  = pe;
      pipe_rd_addr = pa;
      pipe_rd_data = pd;
    end
    if (!(mdu_valid && !last_ready)) begin
      mdu_valid   = mv;
      mdu_rd_addr = ma;
      mdu_rd_data = md;
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_q_count", q_count, 0);
    chk("reset_mdu_ready", mdu_ready, 1);
    rst = 1'b0;

    // Reset mid-traffic with two queued results
    drv(1, 9, 64'h9999, 1, 3, 64'h33);
    drv(1, 10, 64'hAAAA, 1, 4, 64'h44);
    #2;
    chk("pre_reset_q_count", q_count, mq.size());
    rst = 1'b1;
    #1;
    chk("async_rst_rf_we", rf_we, 0);
    chk("async_rst_q_count", q_count, 0);
    chk("async_rst_mdu_ready", mdu_ready, 1);
    chk("async_rst_stall", stall_req, 0);
    chk("async_rst_waddr", rf_waddr, 0);
    chk("async_rst_wdata", rf_wdata, 0);
    mq.delete();
    sb.delete();
    starve_m   = 0;
    last_stall = 0;
    last_ready = 1;
    pipe_rd_ena = 0;
    mdu_valid   = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pipe only, then x0 destination
    drv(1, 5, 64'h1234, 0, 0, 0);
    drv(1, 0, 64'h9, 0, 0, 0);
    idle(2);

    // MDU result drains into an idle slot
    drv(0, 0, 0, 1, 7, 64'hAA);
    idle(3);

    // Starvation: one queued result, pipe writes every cycle
    drv(1, 1, 64'h100, 1, 8, 64'h88);
    for (int i = 0; i < 8; i++) drv(1, 5'(i + 2), 64'(i + 64'h200), 0, 0, 0);
    idle(3);

    // Full queue under continuous pipe writes; third result must wait
    drv(1, 11, 64'h1100, 1, 12, 64'hC12);
    drv(1, 13, 64'h1300, 1, 14, 64'hC14);
    for (int i = 0; i < 10; i++) drv(1, 5'(i + 15), 64'(i + 64'h300), 1, 20, 64'hC20);
    idle(5);

    // MDU result to x0 is accepted but discarded
    drv(0, 0, 0, 1, 0, 64'hDEAD);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit pe, mv;
      logic [4:0] pa, ma;
      pe = ($urandom_range(0, 9) < 6);
      mv = ($urandom_range(0, 9) < 4);
      pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ma = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      drv(pe, pa, {$urandom, $urandom}, mv, ma, {$urandom, $urandom});
    end

    idle(10);
    chk("scoreboard_drained", sb.size(), 0);
    chk("model_queue_drained", q_count, mq.size());
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
